// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared state encoding and defaults for the multiplier arbiter.
package mult_arb_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;
   localparam int NUM_REQ_DEF = 4;
   localparam int TIMEOUT_DEF = 64;
   localparam int READY_GUARD = 2;
endpackage

// File: rtl/mult_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search starting just after the last grant.
module rr_picker #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] last,
   output logic [N-1:0]   grant,
   output logic [IDW-1:0] idx,
   output logic           any
);
   logic [2*N-1:0] dbl;
   int off;
   int sum;
   // Doubling the vector turns the rotation into a plain shift; lowest set bit wins.
   always_comb begin
      dbl = {req, req} >> (last + 1'b1);
      any = 1'b0;
      off = 0;
      for (int k = N - 1; k >= 0; k--)
         if (dbl[k]) begin
            any = 1'b1;
            off = k;
         end
      sum = int'(last) + 1 + off;
      idx = IDW'(sum >= N ? sum - N : sum);
      grant = any ? N'(1) << idx : '0;
   end
endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one multi-cycle multiplier with a ready watchdog.
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*32-1:0] req_a,
   input  logic [NUM_REQ*32-1:0] req_b,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [NUM_REQ-1:0]    resp_valid,
   input  logic [NUM_REQ-1:0]    resp_ready,
   output logic [31:0]           resp_result,
   output logic                  resp_exception,
   output logic                  resp_timeout,
   output logic [IDW-1:0]        resp_id,
   output logic                  busy,
   output logic [31:0]           mult_multiplicand,
   output logic [31:0]           mult_multiplier,
   output logic                  mult_ctrl,
   input  logic                  mult_ready,
   input  logic [31:0]           mult_result,
   input  logic                  mult_exception
);
   localparam int CW = $clog2(TIMEOUT + 1);
   state_t state, state_nxt;
   logic [IDW-1:0] ptr, pick_idx;
   logic [NUM_REQ-1:0] pick_grant;
   logic pick_any;
   logic [CW-1:0] cnt;
   logic rdy_ok, tmo, accept;
   rr_picker #(.N(NUM_REQ), .IDW(IDW)) u_pick (
      .req   (req_valid),
      .last  (ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );
   // The guard masks a ready left over from the previous operation.
   assign rdy_ok = mult_ready && cnt >= CW'(READY_GUARD);
   assign tmo    = cnt == CW'(TIMEOUT - 1);
   assign accept = resp_ready[resp_id];
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = pick_any ? ISSUE : IDLE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    state_nxt = (rdy_ok || tmo) ? RESP : WAIT;
         default: state_nxt = accept ? IDLE : RESP;
      endcase
   end
   always_comb begin
      req_ready  = (state == IDLE && reset) ? pick_grant : '0;
      mult_ctrl  = state == ISSUE;
      resp_valid = state == RESP ? NUM_REQ'(1) << resp_id : '0;
      busy       = state != IDLE;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mult_multiplicand <= '0;
         mult_multiplier   <= '0;
         resp_id           <= '0;
         resp_result       <= '0;
         resp_exception    <= 1'b0;
         resp_timeout      <= 1'b0;
         cnt               <= '0;
         ptr               <= IDW'(NUM_REQ - 1);
      end else begin
         if (state == IDLE && pick_any) begin
            mult_multiplicand <= req_a[{pick_idx, 5'd0} +: 32];
            mult_multiplier   <= req_b[{pick_idx, 5'd0} +: 32];
            resp_id           <= pick_idx;
         end
         cnt <= state == ISSUE ? '0 : state == WAIT ? cnt + 1'b1 : cnt;
         if (state == WAIT && (rdy_ok || tmo)) begin
            resp_result    <= rdy_ok ? mult_result : '0;
            resp_exception <= rdy_ok ? mult_exception : 1'b1;
            resp_timeout   <= !rdy_ok;
         end
         if (state == RESP && accept) ptr <= resp_id;
      end
   end
endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one multi-cycle multiply unit between NUM_REQ requesters, such as the CPU execute stage and the hash-schedule helpers.
- Arbitrates requests round-robin and latches the winner's operands, holding them stable for the whole operation.
- Pulses the multiplier start for one cycle, waits for its ready, then returns the result and exception to the winner over a valid/ready response.
- A watchdog aborts an operation whose ready never arrives.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, maximum WAIT cycles before abort (must exceed multiplier latency of about 18).
- IDW, 2, requester index width, equal to clog2(NUM_REQ).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_a  in  NUM_REQ*32  multiplicands, slice i belongs to requester i.
- req_b  in  NUM_REQ*32  multipliers, slice i.
- req_ready  out  NUM_REQ  one-hot grant/accept pulse.
- resp_valid  out  NUM_REQ  one-hot response valid.
- resp_ready  in  NUM_REQ  per-requester response accept.
- resp_result  out  32  product low word.
- resp_exception  out  1  multiplier overflow or timeout.
- resp_timeout  out  1  set only on watchdog abort.
- resp_id  out  IDW  index of responding requester.
- busy  out  1  high in any state other than IDLE.
- mult_multiplicand  out  32  latched operand a.
- mult_multiplier  out  32  latched operand b.
- mult_ctrl  out  1  one-cycle start pulse.
- mult_ready  in  1  multiplier done.
- mult_result  in  32  multiplier product.
- mult_exception  in  1  multiplier overflow flag.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including operands and resp_id.
  - The round-robin pointer is set so requester 0 has highest priority.
- IDLE:
  - If any req_valid is set, pick the winner by round-robin, starting the search at the index after the last grant.
  - Assert req_ready[winner] for exactly this cycle.
  - Latch req_a/req_b slices into mult_multiplicand/mult_multiplier, latch the winner into resp_id, then go to ISSUE.
  - The request counts as accepted on req_valid & req_ready in that cycle.
- ISSUE:
  - Assert mult_ctrl=1 for one cycle and clear the wait counter.
  - Go to WAIT.
- WAIT:
  - mult_ctrl=0 and the wait counter increments every cycle.
  - mult_ready is ignored while the counter is below 2; this masks stale ready from the previous operation.
  - When mult_ready is high and the counter is 2 or more:
    - register mult_result into resp_result and mult_exception into resp_exception;
    - set resp_timeout=0;
    - go to RESP.
  - When the counter reaches TIMEOUT without a qualifying ready:
    - resp_result=0, resp_exception=1, resp_timeout=1;
    - go to RESP.
  - If ready and timeout occur in the same cycle, ready wins.
- RESP:
  - resp_valid[resp_id]=1; all response outputs are held stable until resp_ready[resp_id]=1.
  - On accept, update the pointer to resp_id and go to IDLE.
  - resp_ready bits of other requesters are ignored.
- Handshake rules:
  - No new grant is issued in the same cycle as a response accept; the minimum request-to-request spacing is 1 IDLE cycle.
  - Operands stay constant from the grant until the next grant. The multiplier samples them throughout its run.
  - Latency: grant in cycle G, mult_ctrl in G+1, multiplier ready in cycle R, resp_valid from R+1.
- Reset mid-operation:
  - The controller returns to IDLE immediately.
  - The multiplier itself is not reset, so its in-flight ready is discarded (IDLE ignores mult_ready).
  - Requesters must re-issue.
- A requester that drops req_valid before it is granted is simply skipped; no state is kept for it.

Decomposition:
- Shared package mult_arb_pkg holds:
  - state encodings IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3;
  - the default NUM_REQ and TIMEOUT;
  - the wait-guard constant READY_GUARD=2.
- One sub-module, rr_picker:
  - pure combinational round-robin over NUM_REQ;
  - inputs: request vector and last-grant index;
  - outputs: one-hot grant, index, and any-valid.
- The FSM, operand/response registers and watchdog counter live in mult_arbiter.

Test Plan:
- Single op: requester 1 sends a=6, b=7 with resp_ready=1 and a multiplier model of latency 18 → req_ready=4'b0010 for one cycle, mult_ctrl one pulse, then resp_valid=4'b0010, resp_result=42, resp_exception=0, resp_id=1.
- Fairness: all 4 requesters held valid with operands i+1 and 3, for 8 operations → grant order 0,1,2,3,0,1,2,3; results 3,6,9,12 repeating.
- Backpressure: resp_ready[0] held low for 10 cycles after resp_valid → resp_result/resp_valid stay stable, no new grant and busy=1; result released the cycle after resp_ready=1.
- Overflow: a=32'h00010000, b=32'h00010000 with the model raising exception → resp_exception=1, resp_timeout=0.
- Timeout: mult_ready tied low → after TIMEOUT=64 WAIT cycles resp_valid is asserted with resp_result=0, resp_exception=1, resp_timeout=1. A stale mult_ready pulse one cycle after ISSUE is ignored.
- Reset mid-WAIT: assert reset low at WAIT cycle 5 → all outputs 0 immediately. A late mult_ready after release produces no resp_valid, and the next request goes to requester 0 first.
